// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, configuration and uart-side signals of the arbiter.
// slave is the arbiter's view, master is the client/uart environment's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 9,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cfg_req;
  logic                          cfg_done;
  logic                          uart_tx;
  logic [DATA_WIDTH-1:0]         uart_tx_data;
  logic                          uart_tx_busy;
  logic                          uart_config_set;
  logic                          uart_config_ack;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          err_timeout;
  modport slave (
    input  req_valid, req_data, cfg_req, uart_tx_busy, uart_config_ack,
    output req_ready, cfg_done, uart_tx, uart_tx_data, uart_config_set, grant_id, err_timeout
  );
  modport master (
    output req_valid, req_data, cfg_req, uart_tx_busy, uart_config_ack,
    input  req_ready, cfg_done, uart_tx, uart_tx_data, uart_config_set, grant_id, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter with config updates applied only while idle.
// Defining UART_ARB_TIMEOUT_EN adds a BUSY_TIMEOUT-cycle watchdog on tx_busy rising after each tx pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 9,
  parameter int BUSY_TIMEOUT = 16,
  parameter int ID_WIDTH     = 2
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] CFG_SET   = 3'd4;
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WIDTH < $clog2(NUM_REQ) || BUSY_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: illegal parameter combination");
  end
  logic [2:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  uart_tx_q, uart_tx_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  config_set_q, config_set_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic                  found;
  logic [ID_WIDTH-1:0]   pick;
  int                    idx;
  // Search starts just after the last grant so a held request cannot starve the others.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_timeout_q, err_timeout_d;
  logic          expired;
  assign expired = cnt_q == CW'(BUSY_TIMEOUT - 1);
  assign cnt_d   = state_q == WAIT_BUSY ? cnt_q + 1'b1 : '0;
`endif
  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    uart_tx_d    = 1'b0;
    cfg_done_d   = 1'b0;
    config_set_d = config_set_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (!bus.uart_tx_busy && bus.cfg_req) begin
          state_d      = CFG_SET;
          config_set_d = 1'b1;
        end else if (!bus.uart_tx_busy && found) begin
          state_d     = ISSUE;
          tx_data_d   = bus.req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          grant_d     = pick;
          uart_tx_d   = 1'b1;
          req_ready_d = NUM_REQ'(1) << pick;
        end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (bus.uart_tx_busy) state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        else if (expired) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end
`endif
      WAIT_DONE: state_d = bus.uart_tx_busy ? WAIT_DONE : IDLE;
      CFG_SET:
        if (bus.uart_config_ack) begin
          state_d      = IDLE;
          config_set_d = 1'b0;
          cfg_done_d   = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      uart_tx_q    <= 1'b0;
      cfg_done_q   <= 1'b0;
      config_set_q <= 1'b0;
      tx_data_q    <= '0;
      grant_q      <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      uart_tx_q    <= uart_tx_d;
      cfg_done_q   <= cfg_done_d;
      config_set_q <= config_set_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign bus.err_timeout = err_timeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
  assign bus.req_ready       = req_ready_q;
  assign bus.uart_tx         = uart_tx_q;
  assign bus.cfg_done        = cfg_done_q;
  assign bus.uart_config_set = config_set_q;
  assign bus.uart_tx_data    = tx_data_q;
  assign bus.grant_id        = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench; a rotation model predicts every grant and word.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int ID = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(ID)) u();
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .BUSY_TIMEOUT(16), .ID_WIDTH(ID)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u)
  );
  typedef struct packed {
    logic [ID-1:0] id;
    logic [W-1:0]  data;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] words[N][$];
  logic [N-1:0]   rv = '0;
  logic [N*W-1:0] rd = '0;
  logic mbusy = 1'b0, fbusy = 1'b0, cfg = 1'b0, ack = 1'b0;
  assign u.req_valid       = rv;
  assign u.req_data        = rd;
  assign u.uart_tx_busy    = mbusy | fbusy;
  assign u.cfg_req         = cfg;
  assign u.uart_config_ack = ack;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, tx_cnt = 0, tx_cyc = 0, fall_cyc = -100, err_cyc = -1;
  int lat = 2, hold = 20, rise_in = 0, hold_left = 0;
  bit never_raise = 1'b0;
  int mdl_last = N - 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      rv[i]        = words[i].size() > 0;
      rd[i*W +: W] = words[i].size() > 0 ? words[i][0] : '0;
    end
  endfunction

  // Expected grant order: repeatedly take the first pending requester after the previous winner.
  function automatic void plan();
    int left[N];
    int j;
    for (int i = 0; i < N; i++) left[i] = words[i].size();
    while (1) begin
      j = -1;
      for (int k = 1; k <= N; k++)
        if (j < 0 && left[(mdl_last + k) % N] > 0) j = (mdl_last + k) % N;
      if (j < 0) break;
      sb.push_back('{id: ID'(j), data: words[j][words[j].size() - left[j]]});
      left[j]--;
      mdl_last = j;
    end
  endfunction

  // One cycle: observe outputs, run the uart model, retire accepted words, re-drive requesters.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (u.uart_tx) begin
      tx_cnt++;
      tx_cyc = cyc;
    end
    if (u.err_timeout) err_cyc = cyc;
    for (int i = 0; i < N; i++)
      if (u.req_ready[i] && words[i].size() > 0) void'(words[i].pop_front());
    if (u.uart_tx) rise_in = never_raise ? 0 : lat;
    else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        mbusy = 1'b1;
        hold_left = hold;
      end
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        mbusy = 1'b0;
        fall_cyc = cyc;
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb.size() > 0 || mbusy || rise_in > 0 || hold_left > 0) && t < budget) begin
      tick();
      t++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (3) tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && u.uart_tx) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_tx: id %0d data %0h with nothing expected", u.grant_id, u.uart_tx_data);
        end else begin
          e = sb.pop_front();
          check("grant_id", 32'(u.grant_id), 32'(e.id));
          check("tx_data", 32'(u.uart_tx_data), 32'(e.data));
          check("req_ready", 32'(u.req_ready), 32'(1) << e.id);
        end
      end else if (u.req_ready != '0) check("stray_ready", 32'(u.req_ready), 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, t, set_cyc;
    bit done;
    drive();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(u.uart_tx), 0);
    check("rst_ready", 32'(u.req_ready), 0);
    check("rst_data", 32'(u.uart_tx_data), 0);
    check("rst_grant", 32'(u.grant_id), N - 1);
    check("rst_cfg", 32'({u.cfg_done, u.uart_config_set, u.err_timeout}), 0);
    rst_n = 1'b1;
    // Round robin: requesters 0,1 hold two words, 2,3 one, so grants run 0,1,2,3,0,1.
    lat = 1; hold = 3;
    for (int i = 0; i < N; i++) for (int k = 0; k < (i < 2 ? 2 : 1); k++) words[i].push_back(W'($urandom));
    plan(); drive();
    drain(300);
    // Single requester with fixed-latency uart and the busy-fall to next-tx gap.
    lat = 2; hold = 20;
    words[0].push_back(9'h0A5);
    words[0].push_back(W'($urandom));
    plan(); drive();
    base = tx_cnt; t = 0;
    while (tx_cnt < base + 2 && t < 200) begin tick(); t++; end
    check("gap_after_busy", tx_cyc - fall_cyc, 2);
    drain(200);
    // Config takes priority over a simultaneous data request.
    cfg = 1'b1;
    words[2].push_back(W'($urandom));
    plan(); drive();
    base = tx_cnt; set_cyc = 0; done = 1'b0; t = 0;
    while (!done && t < 50) begin
      tick(); t++;
      if (u.uart_config_set) begin
        set_cyc++;
        if (set_cyc == 3) ack = 1'b1;
      end
      if (u.cfg_done) begin
        done = 1'b1; cfg = 1'b0; ack = 1'b0;
      end
    end
    check("cfg_set_cycles", set_cyc, 3);
    check("cfg_done_seen", 32'(done), 1);
    check("no_tx_during_cfg", tx_cnt - base, 0);
    tick();
    check("cfg_done_pulse", 32'(u.cfg_done), 0);
    drain(200);
    check("tx_after_cfg", tx_cnt - base, 1);
    // External busy gates all grants.
    fbusy = 1'b1;
    words[1].push_back(W'($urandom));
    plan(); drive();
    base = tx_cnt;
    repeat (10) tick();
    check("gated_tx", tx_cnt - base, 0);
    fbusy = 1'b0;
    drain(200);
    check("released_tx", tx_cnt - base, 1);
    // Uart that never raises busy.
    never_raise = 1'b1;
    base = tx_cnt; err_cyc = -1;
`ifdef UART_ARB_TIMEOUT_EN
    words[3].push_back(W'($urandom));
    words[0].push_back(W'($urandom));
    plan(); drive();
    t = 0;
    while (err_cyc < 0 && t < 80) begin tick(); t++; end
    check("timeout_delay", err_cyc - tx_cyc, 17);
    never_raise = 1'b0;
    drain(200);
    check("tx_after_timeout", tx_cnt - base, 2);
`else
    words[3].push_back(W'($urandom));
    plan(); drive();
    repeat (40) tick();
    check("no_err_timeout", err_cyc, -1);
    words[0].push_back(W'($urandom));
    plan(); drive();
    repeat (10) tick();
    check("stuck_wait_busy", tx_cnt - base, 1);
    never_raise = 1'b0;
    fbusy = 1'b1;
    repeat (3) tick();
    fbusy = 1'b0;
    drain(200);
    check("tx_after_late_busy", tx_cnt - base, 2);
`endif
    // Reset while the uart is busy.
    lat = 2; hold = 20;
    words[1].push_back(W'($urandom));
    plan(); drive();
    t = 0;
    while (!(mbusy && hold_left < 16) && t < 50) begin tick(); t++; end
    check("mid_reset_reached_busy", 32'(mbusy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(u.uart_tx), 0);
    check("arst_ready", 32'(u.req_ready), 0);
    check("arst_data", 32'(u.uart_tx_data), 0);
    check("arst_grant", 32'(u.grant_id), N - 1);
    check("arst_cfg", 32'({u.cfg_done, u.uart_config_set, u.err_timeout}), 0);
    mbusy = 1'b0; rise_in = 0; hold_left = 0; mdl_last = N - 1;
    for (int i = 0; i < N; i++) words[i].push_back(W'($urandom));
    plan(); drive();
    @(negedge clk);
    rst_n = 1'b1;
    drain(400);
    // Randomized request mixes and uart latencies.
    for (int r = 0; r < 12; r++) begin
      lat  = $urandom_range(1, 3);
      hold = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = $urandom_range(0, 3);
        for (int k = 0; k < cnt; k++) words[i].push_back(W'($urandom));
      end
      plan(); drive();
      drain(600);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
